// File: rtl/nios2_dbg_jtag_host.sv
// JTAG host for the Nios II debug TAP: generates TCK/TMS/TDI for IR/DR scans
// and captures TDO, tracking the 1149.1 TAP state on every TCK rise.
module nios2_dbg_jtag_host #(
  parameter int DR_W     = 38,
  parameter int TCK_HALF = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_is_ir,
  input  logic [5:0]      cmd_len,
  input  logic [DR_W-1:0] cmd_data,
  output logic            rsp_valid,
  output logic [DR_W-1:0] rsp_data,
  output logic            tck,
  output logic            tms,
  output logic            tdi,
  input  logic            tdo,
  output logic            busy
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_HDR   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_TAIL  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [3:0] T_TLR = 4'h0, T_RTI = 4'h1, T_SDS = 4'h2;
  localparam logic [3:0] T_CDR = 4'h3, T_SDR = 4'h4, T_E1D = 4'h5;
  localparam logic [3:0] T_PDR = 4'h6, T_E2D = 4'h7, T_UDR = 4'h8;
  localparam logic [3:0] T_SIS = 4'h9, T_CIR = 4'ha, T_SIR = 4'hb;
  localparam logic [3:0] T_E1I = 4'hc, T_PIR = 4'hd, T_E2I = 4'he;
  localparam logic [3:0] T_UIR = 4'hf;

  localparam logic [8:0] RISE_AT = 9'(TCK_HALF - 1);
  localparam logic [8:0] LAST_AT = 9'(2 * TCK_HALF - 1);
  localparam logic [5:0] LEN_MAX = 6'(DR_W);

  function automatic logic [3:0] tap_nxt(input logic [3:0] s,
                                         input logic m);
    logic [3:0] n;
    unique case (s)
      T_TLR:   n = m ? T_TLR : T_RTI;
      T_RTI:   n = m ? T_SDS : T_RTI;
      T_SDS:   n = m ? T_SIS : T_CDR;
      T_CDR:   n = m ? T_E1D : T_SDR;
      T_SDR:   n = m ? T_E1D : T_SDR;
      T_E1D:   n = m ? T_UDR : T_PDR;
      T_PDR:   n = m ? T_E2D : T_PDR;
      T_E2D:   n = m ? T_UDR : T_SDR;
      T_UDR:   n = m ? T_SDS : T_RTI;
      T_SIS:   n = m ? T_TLR : T_CIR;
      T_CIR:   n = m ? T_E1I : T_SIR;
      T_SIR:   n = m ? T_E1I : T_SIR;
      T_E1I:   n = m ? T_UIR : T_PIR;
      T_PIR:   n = m ? T_E2I : T_PIR;
      T_E2I:   n = m ? T_UIR : T_SIR;
      default: n = m ? T_SDS : T_RTI;
    endcase
    return n;
  endfunction

  logic [2:0]      state_q, state_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [5:0]      bit_q, bit_d;
  logic            tck_q, tck_d;
  logic            tms_q, tms_d;
  logic            tdi_q, tdi_d;
  logic [3:0]      tap_q, tap_d;
  logic            ir_q, ir_d;
  logic [5:0]      len_q, len_d;
  logic [DR_W-1:0] dat_q, dat_d;
  logic [DR_W-1:0] cap_q, cap_d;
  logic [DR_W-1:0] rsp_q, rsp_d;

  logic       run, rise, last;
  logic [5:0] nb, len_m1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    tap_d   = tap_q;
    ir_d    = ir_q;
    len_d   = len_q;
    dat_d   = dat_q;
    cap_d   = cap_q;
    rsp_d   = rsp_q;
    run     = (state_q == S_INIT) || (state_q == S_HDR) ||
              (state_q == S_SHIFT) || (state_q == S_TAIL);
    rise    = run && (cnt_q == RISE_AT);
    last    = run && (cnt_q == LAST_AT);
    nb      = bit_q + 6'd1;
    len_m1  = len_q - 6'd1;

    // One TCK bit = TCK_HALF low cycles then TCK_HALF high cycles
    if (run) begin
      cnt_d = last ? 9'd0 : cnt_q + 9'd1;
      if (rise) tck_d = 1'b1;
      if (last) tck_d = 1'b0;
    end
    if (rise) begin
      tap_d = tap_nxt(tap_q, tms_q);
      if (state_q == S_SHIFT) cap_d[bit_q] = tdo;
    end

    unique case (state_q)
      S_INIT: begin
        if (last) begin
          if (bit_q == 6'd5) begin
            state_d = S_IDLE;
            bit_d   = 6'd0;
          end else begin
            bit_d = nb;
            tms_d = (nb < 6'd5);
          end
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_HDR;
          bit_d   = 6'd0;
          cnt_d   = 9'd0;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
          ir_d    = cmd_is_ir;
          dat_d   = cmd_data;
          cap_d   = '0;
          if (cmd_len == 6'd0)        len_d = 6'd1;
          else if (cmd_len > LEN_MAX) len_d = LEN_MAX;
          else                        len_d = cmd_len;
        end
      end
      S_HDR: begin
        if (last) begin
          if (bit_q == (ir_q ? 6'd3 : 6'd2)) begin
            state_d = S_SHIFT;
            bit_d   = 6'd0;
            tms_d   = (len_q == 6'd1);
            tdi_d   = dat_q[0];
          end else begin
            bit_d = nb;
            tms_d = ir_q && (nb == 6'd1);
          end
        end
      end
      S_SHIFT: begin
        if (last) begin
          if (bit_q == len_m1) begin
            state_d = S_TAIL;
            bit_d   = 6'd0;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            bit_d = nb;
            tms_d = (nb == len_m1);
            tdi_d = dat_q[nb];
          end
        end
      end
      S_TAIL: begin
        if (last) begin
          if (bit_q == 6'd1) begin
            state_d = S_DONE;
            rsp_d   = cap_q;
          end else begin
            bit_d = 6'd1;
            tms_d = 1'b0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      cnt_q   <= 9'd0;
      bit_q   <= 6'd0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      tap_q   <= T_TLR;
      ir_q    <= 1'b0;
      len_q   <= 6'd1;
      dat_q   <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      tap_q   <= tap_d;
      ir_q    <= ir_d;
      len_q   <= len_d;
      dat_q   <= dat_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = rsp_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_nios2_dbg_jtag_host.sv
// Bench for nios2_dbg_jtag_host: TDI->TDO loopback target, tck-edge logging
// and a spec-level scan model compared against randomized scans.
module tb_nios2_dbg_jtag_host;
  localparam int DR_W = 38;
  localparam int TH   = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_is_ir = 1'b0;
  logic [5:0]      cmd_len = 6'd0;
  logic [DR_W-1:0] cmd_data = '0;
  logic            tdo = 1'b0;
  logic            lb = 1'b0;
  logic            cmd_ready, rsp_valid, tck, tms, tdi, busy;
  logic [DR_W-1:0] rsp_data;

  nios2_dbg_jtag_host #(.DR_W(DR_W), .TCK_HALF(TH)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit tms_log[$];
  bit tdi_log[$];
  int btap = 0;
  int pulses = 0, accepts = 0, busy_acc = 0;
  int hi_run = 0, hi_bad = 0, edge_bad = 0;
  logic p_tms = 1'b1, p_tdi = 1'b0, tck_p = 1'b0;

  int s0, lat, npul;
  bit held;
  logic [DR_W-1:0] rsp_got;

  // Target side: TDO returns the TDI seen one TCK earlier
  always @(posedge tck) lb <= tdi;
  always @(negedge tck) tdo <= lb;

  always @(posedge tck) begin
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
  end

  function automatic int tap_next(int s, bit m);
    case (s)
      0: return m ? 0 : 1;
      1: return m ? 2 : 1;
      2: return m ? 9 : 3;
      3: return m ? 5 : 4;
      4: return m ? 5 : 4;
      5: return m ? 8 : 6;
      6: return m ? 7 : 6;
      7: return m ? 8 : 4;
      8: return m ? 2 : 1;
      9: return m ? 0 : 10;
      10: return m ? 12 : 11;
      11: return m ? 12 : 11;
      12: return m ? 15 : 13;
      13: return m ? 14 : 13;
      14: return m ? 15 : 11;
      default: return m ? 2 : 1;
    endcase
  endfunction

  always @(posedge tck or negedge reset_n)
    if (!reset_n) btap <= 0;
    else btap <= tap_next(btap, tms);

  always @(posedge clk) begin
    if (rsp_valid) pulses <= pulses + 1;
    if (cmd_valid && cmd_ready) begin
      accepts <= accepts + 1;
      if (busy) busy_acc <= busy_acc + 1;
    end
  end

  always @(negedge clk) begin
    hi_run <= tck ? hi_run + 1 : 0;
    if (!tck && tck_p && reset_n && hi_run != TH) hi_bad <= hi_bad + 1;
    if (tck && (tms !== p_tms || tdi !== p_tdi)) edge_bad <= edge_bad + 1;
    p_tms <= tms;
    p_tdi <= tdi;
    tck_p <= tck;
  end

  function automatic int eff_len(int l);
    if (l == 0) return 1;
    if (l > DR_W) return DR_W;
    return l;
  endfunction

  function automatic bit exp_tms(bit ir, int l, int k);
    int h = ir ? 4 : 3;
    if (k < h) return (k == 0) || (ir && k == 1);
    if (k < h + l) return k == h + l - 1;
    return k == h + l;
  endfunction

  function automatic logic [DR_W-1:0] exp_rsp(logic [DR_W-1:0] d, int l);
    logic [DR_W-1:0] r = '0;
    for (int i = 1; i < l; i++) r[i] = d[i-1];
    return r;
  endfunction

  function automatic logic [DR_W-1:0] rnd_data();
    logic [63:0] t = {$urandom(), $urandom()};
    return t[DR_W-1:0];
  endfunction

  task automatic run_scan(input bit ir, input int len,
                          input logic [DR_W-1:0] data);
    int n = 0;
    int p0;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!cmd_ready) begin
      bad++;
      $display("FAIL ready_wait got=0 want=1");
    end
    s0 = tms_log.size();
    p0 = pulses;
    cmd_valid = 1'b1;
    cmd_is_ir = ir;
    cmd_len = 6'(len);
    cmd_data = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    rsp_got = rsp_data;
    repeat (3) @(negedge clk);
    npul = pulses - p0;
    held = (rsp_data === rsp_got);
  endtask

  task automatic test_reset();
    int n = 0;
    bit want[6] = '{1, 1, 1, 1, 1, 0};
    int mis = 0;
    repeat (4) @(negedge clk);
    total += 7;
    if (tck !== 1'b0) begin bad++; $display("FAIL rst_tck got=%b want=0", tck); end
    if (tms !== 1'b1) begin bad++; $display("FAIL rst_tms got=%b want=1", tms); end
    if (tdi !== 1'b0) begin bad++; $display("FAIL rst_tdi got=%b want=0", tdi); end
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", cmd_ready); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rspv got=%b want=0", rsp_valid); end
    if (rsp_data !== '0) begin bad++; $display("FAIL rst_rspd got=%h want=0", rsp_data); end
    if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b want=1", busy); end
    s0 = tms_log.size();
    reset_n = 1'b1;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n < 12 * TH || n > 12 * TH + 2) begin
      bad++;
      $display("FAIL init_ready_time got=%0d want=%0d..%0d", n, 12 * TH, 12 * TH + 2);
    end
    total++;
    if (tms_log.size() - s0 != 6) begin
      bad++;
      $display("FAIL init_bits got=%0d want=6", tms_log.size() - s0);
    end else begin
      for (int k = 0; k < 6; k++) if (tms_log[s0+k] != want[k]) mis++;
      total++;
      if (mis != 0) begin bad++; $display("FAIL init_tms got=%0d_wrong want=0_wrong", mis); end
    end
    total++;
    if (btap != 1) begin bad++; $display("FAIL init_tap got=%0d want=1", btap); end
  endtask

  task automatic test_dr_known();
    logic [DR_W-1:0] d = 38'h2A_5555_AAAA;
    run_scan(1'b0, 38, d);
    total += 5;
    if (tms_log.size() - s0 != 43) begin
      bad++; $display("FAIL dr38_bits got=%0d want=43", tms_log.size() - s0);
    end
    if (rsp_got !== exp_rsp(d, 38)) begin
      bad++; $display("FAIL dr38_rsp got=%h want=%h", rsp_got, exp_rsp(d, 38));
    end
    if (npul != 1) begin bad++; $display("FAIL dr38_pulses got=%0d want=1", npul); end
    if (lat + 1 < 2 * TH * 43 + 1 || lat + 1 > 2 * TH * 43 + 3) begin
      bad++; $display("FAIL dr38_latency got=%0d want=%0d", lat + 1, 2 * TH * 43 + 2);
    end
    if (!held) begin bad++; $display("FAIL dr38_hold got=%h want=%h", rsp_data, rsp_got); end
  endtask

  task automatic test_ir2();
    bit want[8] = '{1, 1, 0, 0, 0, 1, 1, 0};
    int mis = 0;
    logic [DR_W-1:0] d = 38'b10;
    run_scan(1'b1, 2, d);
    total++;
    if (tms_log.size() - s0 != 8) begin
      bad++; $display("FAIL ir2_bits got=%0d want=8", tms_log.size() - s0);
    end else begin
      for (int k = 0; k < 8; k++) if (tms_log[s0+k] != want[k]) mis++;
      total += 2;
      if (mis != 0) begin bad++; $display("FAIL ir2_tms got=%0d_wrong want=0_wrong", mis); end
      if ({tdi_log[s0+4], tdi_log[s0+5]} != 2'b01) begin
        bad++; $display("FAIL ir2_tdi got=%b%b want=01", tdi_log[s0+4], tdi_log[s0+5]);
      end
    end
    total++;
    if (btap != 1) begin bad++; $display("FAIL ir2_tap got=%0d want=1", btap); end
  endtask

  task automatic test_len1();
    logic [DR_W-1:0] d = rnd_data();
    run_scan(1'b0, 1, d);
    total += 3;
    if (tms_log.size() - s0 != 6) begin
      bad++; $display("FAIL len1_bits got=%0d want=6", tms_log.size() - s0);
    end
    if (tms_log.size() - s0 < 4 || tms_log[s0+3] != 1'b1) begin
      bad++; $display("FAIL len1_tms got=0 want=1");
    end
    if (rsp_got !== '0) begin bad++; $display("FAIL len1_rsp got=%h want=0", rsp_got); end
  endtask

  task automatic test_clamp();
    logic [DR_W-1:0] d = rnd_data();
    run_scan(1'b0, 0, d);
    total++;
    if (tms_log.size() - s0 != 6) begin
      bad++; $display("FAIL clamp0_bits got=%0d want=6", tms_log.size() - s0);
    end
    run_scan(1'b1, 50, d);
    total += 2;
    if (tms_log.size() - s0 != 44) begin
      bad++; $display("FAIL clamp50_bits got=%0d want=44", tms_log.size() - s0);
    end
    if (rsp_got !== exp_rsp(d, DR_W)) begin
      bad++; $display("FAIL clamp50_rsp got=%h want=%h", rsp_got, exp_rsp(d, DR_W));
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      bit ir = 1'($urandom_range(0, 1));
      int len = $urandom_range(0, 42);
      int l = eff_len(len);
      int h = ir ? 4 : 3;
      int nb = h + l + 2;
      int mt = 0, md = 0;
      logic [DR_W-1:0] d = rnd_data();
      run_scan(ir, len, d);
      total++;
      if (tms_log.size() - s0 != nb) begin
        bad++;
        $display("FAIL rnd%0d_bits got=%0d want=%0d", it, tms_log.size() - s0, nb);
      end else begin
        for (int k = 0; k < nb; k++) if (tms_log[s0+k] != exp_tms(ir, l, k)) mt++;
        for (int i = 0; i < l; i++) if (tdi_log[s0+h+i] != d[i]) md++;
        total += 2;
        if (mt != 0) begin bad++; $display("FAIL rnd%0d_tms got=%0d_wrong want=0_wrong", it, mt); end
        if (md != 0) begin bad++; $display("FAIL rnd%0d_tdi got=%0d_wrong want=0_wrong", it, md); end
      end
      total += 4;
      if (rsp_got !== exp_rsp(d, l)) begin
        bad++; $display("FAIL rnd%0d_rsp got=%h want=%h", it, rsp_got, exp_rsp(d, l));
      end
      if (npul != 1) begin bad++; $display("FAIL rnd%0d_pulses got=%0d want=1", it, npul); end
      if (lat + 1 < 2 * TH * nb + 1 || lat + 1 > 2 * TH * nb + 3) begin
        bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", it, lat + 1, 2 * TH * nb + 2);
      end
      if (btap != 1) begin bad++; $display("FAIL rnd%0d_tap got=%0d want=1", it, btap); end
    end
  endtask

  task automatic test_abort();
    int n = 0;
    int p0, s1;
    int mis = 0;
    bit want[6] = '{1, 1, 1, 1, 1, 0};
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    s0 = tms_log.size();
    p0 = pulses;
    cmd_valid = 1'b1;
    cmd_is_ir = 1'b0;
    cmd_len = 6'd38;
    cmd_data = rnd_data();
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (tms_log.size() - s0 < 13 && n < 2000) begin @(negedge clk); n++; end
    #2 reset_n = 1'b0;
    #1;
    total += 5;
    if (tck !== 1'b0) begin bad++; $display("FAIL abort_tck got=%b want=0", tck); end
    if (tms !== 1'b1) begin bad++; $display("FAIL abort_tms got=%b want=1", tms); end
    if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy got=%b want=1", busy); end
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b want=0", cmd_ready); end
    if (rsp_data !== '0) begin bad++; $display("FAIL abort_rspd got=%h want=0", rsp_data); end
    repeat (5) @(negedge clk);
    s1 = tms_log.size();
    reset_n = 1'b1;
    n = 0;
    while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
    total += 3;
    if (pulses != p0) begin bad++; $display("FAIL abort_pulses got=%0d want=0", pulses - p0); end
    if (tms_log.size() - s1 != 6) begin
      bad++; $display("FAIL abort_init_bits got=%0d want=6", tms_log.size() - s1);
    end else begin
      for (int k = 0; k < 6; k++) if (tms_log[s1+k] != want[k]) mis++;
      if (mis != 0) begin bad++; $display("FAIL abort_init_tms got=%0d_wrong want=0_wrong", mis); end
    end
    if (btap != 1) begin bad++; $display("FAIL abort_tap got=%0d want=1", btap); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int a0, p0, b0;
    @(negedge clk);
    a0 = accepts;
    p0 = pulses;
    b0 = busy_acc;
    cmd_is_ir = 1'b0;
    cmd_len = 6'($urandom_range(1, 8));
    cmd_data = rnd_data();
    cmd_valid = 1'b1;
    while (pulses - p0 < 3 && n < 20000) begin
      @(negedge clk);
      n++;
      if (accepts - a0 >= 3) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    total += 3;
    if (accepts - a0 != 3) begin bad++; $display("FAIL b2b_accepts got=%0d want=3", accepts - a0); end
    if (pulses - p0 != 3) begin bad++; $display("FAIL b2b_pulses got=%0d want=3", pulses - p0); end
    if (busy_acc != b0) begin bad++; $display("FAIL b2b_busy_accept got=%0d want=0", busy_acc - b0); end
  endtask

  initial begin
    test_reset();
    test_dr_known();
    test_ir2();
    test_len1();
    test_clamp();
    test_random();
    test_abort();
    test_back_to_back();
    total += 2;
    if (hi_bad != 0) begin bad++; $display("FAIL tck_high_len got=%0d_bad want=0_bad", hi_bad); end
    if (edge_bad != 0) begin bad++; $display("FAIL drive_edge got=%0d_bad want=0_bad", edge_bad); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
